// File: rtl/gshare_predictor_pkg.sv
// Shared types and helpers for the gshare predictor: counter reset value,
// saturating counter step and the BTB entry layout.
// Pure definitions; no logic, no latency, no backpressure.
package gshare_predictor_pkg;

  // Widest counter and widest tag the predictor can be configured for.
  localparam int CNT_MAX_W     = 4;
  localparam int BTB_TAG_MAX_W = 30;

  typedef logic [CNT_MAX_W-1:0]     cnt_t;
  typedef logic [BTB_TAG_MAX_W-1:0] btb_tag_t;

  // Tags are stored zero-extended to the widest possible tag.
  typedef struct packed {
    logic        valid;
    btb_tag_t    tag;
    logic [31:0] target;
  } btb_entry_t;

  // Weakly not-taken: one below the taken threshold.
  function automatic cnt_t cnt_reset_val(input int unsigned w);
    return cnt_t'((1 << (w - 1)) - 1);
  endfunction

  // Saturating up/down step for a w-bit counter held in a cnt_t.
  function automatic cnt_t cnt_sat_update(input cnt_t cnt, input logic taken,
                                          input int unsigned w);
    cnt_t max_v;
    max_v = cnt_t'((1 << w) - 1);
    if (taken) begin
      return (cnt == max_v) ? cnt : cnt + cnt_t'(1);
    end
    return (cnt == '0) ? cnt : cnt - cnt_t'(1);
  endfunction

endpackage

// File: rtl/predictor_btb.sv
// Direct-mapped tagged branch target buffer with combinational lookup.
// Lookup latency 0 cycles; writes visible the cycle after the write edge.
// No backpressure: writes are dropped while rdy_i is low, reset clears valids.
module predictor_btb
  import gshare_predictor_pkg::*;
#(
  parameter int BTB_WIDTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rdy_i,
  input  logic [31:0] lookup_pc_i,
  output logic        lookup_hit_o,
  output logic [31:0] lookup_target_o,
  input  logic        wr_en_i,
  input  logic [31:0] wr_pc_i,
  input  logic [31:0] wr_target_i
);

  localparam int SETS = 1 << BTB_WIDTH;

  btb_entry_t           mem_q [SETS];
  btb_entry_t           rd_entry;
  btb_entry_t           wr_d;
  logic [BTB_WIDTH-1:0] rd_set;
  logic [BTB_WIDTH-1:0] wr_set;

  // PC bit 0 never selects a set or forms part of a tag.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i[0], wr_pc_i[0]};

  assign rd_set   = lookup_pc_i[BTB_WIDTH:1];
  assign wr_set   = wr_pc_i[BTB_WIDTH:1];
  assign rd_entry = mem_q[rd_set];

  assign lookup_hit_o    = rd_entry.valid &&
                           (rd_entry.tag == btb_tag_t'(lookup_pc_i[31:BTB_WIDTH+1]));
  assign lookup_target_o = lookup_hit_o ? rd_entry.target : 32'd0;

  // Build the entry that a taken branch installs, replacing whatever was there.
  always_comb begin
    wr_d        = '0;
    wr_d.valid  = 1'b1;
    wr_d.tag    = btb_tag_t'(wr_pc_i[31:BTB_WIDTH+1]);
    wr_d.target = wr_target_i;
  end

  // Entry storage: reset invalidates everything, writes only when ready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SETS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (rdy_i && wr_en_i) begin
      mem_q[wr_set] <= wr_d;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor (PHT of saturating counters, commit-time history) plus BTB.
// Prediction latency 0 cycles (combinational); training visible the cycle after update.
// No backpressure: rdy low freezes all state and drops any update presented.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int PHT_WIDTH  = 6,
  parameter int HIST_WIDTH = 6,
  parameter int CNT_WIDTH  = 2,
  parameter int BTB_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic [31:0]          query_pc,
  output logic                 predict_taken,
  output logic                 predict_hit,
  output logic [31:0]          predict_target,
  output logic [PHT_WIDTH-1:0] predict_index,
  input  logic                 update,
  input  logic [31:0]          update_pc,
  input  logic [PHT_WIDTH-1:0] update_index,
  input  logic                 update_result,
  input  logic [31:0]          update_target
);

  localparam int                   PHT_ENTRIES = 1 << PHT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_RST     = CNT_WIDTH'(cnt_reset_val(CNT_WIDTH));

  logic [CNT_WIDTH-1:0]  pht_q [PHT_ENTRIES];
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic [HIST_WIDTH-1:0] ghr_q;
  logic [HIST_WIDTH-1:0] ghr_d;
  logic                  train;

  assign train = update && rdy;

  // History is zero-extended up to the index width before the XOR.
  assign predict_index = query_pc[PHT_WIDTH:1] ^ PHT_WIDTH'(ghr_q);
  assign predict_taken = pht_q[predict_index][CNT_WIDTH-1];

  // The index comes back from fetch, so training never recomputes it from the PC.
  assign cnt_d = CNT_WIDTH'(cnt_sat_update(cnt_t'(pht_q[update_index]), update_result,
                                           CNT_WIDTH));

  if (HIST_WIDTH == 1) begin : g_hist1
    assign ghr_d = update_result;
  end else begin : g_histn
    assign ghr_d = {ghr_q[HIST_WIDTH-2:0], update_result};
  end

  // Counter table and committed history; reset takes priority over training.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        pht_q[i] <= CNT_RST;
      end
      ghr_q <= '0;
    end else if (train) begin
      pht_q[update_index] <= cnt_d;
      ghr_q               <= ghr_d;
    end
  end

  // Only taken branches install a target.
  predictor_btb #(
    .BTB_WIDTH (BTB_WIDTH)
  ) u_btb (
    .clk_i           (clk),
    .rst_i           (rst),
    .rdy_i           (rdy),
    .lookup_pc_i     (query_pc),
    .lookup_hit_o    (predict_hit),
    .lookup_target_o (predict_target),
    .wr_en_i         (update && update_result),
    .wr_pc_i         (update_pc),
    .wr_target_i     (update_target)
  );

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: default build plus a 3-bit counter build.
// Expected predictions are queued when a query is driven and popped when sampled.
// Inputs change on the falling edge; outputs are sampled 2 ns later.
module tb_gshare_predictor;

  typedef struct {
    string       nm;
    logic [39:0] v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [31:0] query_pc, update_pc, update_target;
  logic [5:0]  update_index;
  logic        update, update_result;
  logic        predict_taken, predict_hit;
  logic [31:0] predict_target;
  logic [5:0]  predict_index;

  logic [31:0] query_pc3, update_pc3, update_target3;
  logic [5:0]  update_index3;
  logic        update3, update_result3;
  logic        predict_taken3, predict_hit3;
  logic [31:0] predict_target3;
  logic [5:0]  predict_index3;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [5:0] ghr_m;
  logic [5:0] g3;

  wire [39:0] obs  = {predict_taken, predict_hit, predict_target, predict_index};
  wire [39:0] obs3 = {predict_taken3, predict_hit3, predict_target3, predict_index3};

  localparam logic [31:0] FAR_PC = 32'hF000_0040;

  always #5 clk = ~clk;

  gshare_predictor dut (
    .clk(clk), .rst(rst), .rdy(rdy), .query_pc(query_pc),
    .predict_taken(predict_taken), .predict_hit(predict_hit),
    .predict_target(predict_target), .predict_index(predict_index),
    .update(update), .update_pc(update_pc), .update_index(update_index),
    .update_result(update_result), .update_target(update_target)
  );

  gshare_predictor #(.CNT_WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .rdy(rdy), .query_pc(query_pc3),
    .predict_taken(predict_taken3), .predict_hit(predict_hit3),
    .predict_target(predict_target3), .predict_index(predict_index3),
    .update(update3), .update_pc(update_pc3), .update_index(update_index3),
    .update_result(update_result3), .update_target(update_target3)
  );

  // PC whose index bits XOR the given history to land on idx.
  function automatic logic [31:0] pc_for(input logic [5:0] idx, input logic [5:0] g);
    return {25'd0, idx ^ g, 1'b0};
  endfunction

  task automatic do_reset();
    rst = 1'b1; update = 1'b0; update3 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; ghr_m = '0; g3 = '0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [5:0] idx, input logic res,
                     input logic [31:0] tgt);
    update = 1'b1; update_pc = pc; update_index = idx; update_result = res; update_target = tgt;
    @(negedge clk);
    update = 1'b0;
    if (rdy && !rst) ghr_m = {ghr_m[4:0], res};
  endtask

  task automatic upd3(input logic [5:0] idx, input logic res);
    update3 = 1'b1; update_pc3 = FAR_PC; update_index3 = idx; update_result3 = res;
    update_target3 = 32'h0000_0ABC;
    @(negedge clk);
    update3 = 1'b0;
    if (rdy && !rst) g3 = {g3[4:0], res};
  endtask

  task automatic drive_q(input logic [31:0] pc, input string nm, input logic [39:0] v);
    exp_t e;
    query_pc = pc; e.nm = nm; e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic drive_q3(input logic [31:0] pc, input string nm, input logic [39:0] v);
    exp_t e;
    query_pc3 = pc; e.nm = nm; e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] pcs [2];
    logic [5:0]  idx [2];
    pcs[0] = 32'h100; idx[0] = 6'h00;
    pcs[1] = 32'h040; idx[1] = 6'h20;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive_q(pcs[i], $sformatf("reset pc=%h", pcs[i]), {1'b0, 1'b0, 32'd0, idx[i]});
      #2;
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e.v) begin
        n_bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_counter();
    exp_t e;
    int   nt [7];
    int   nn [7];
    logic ex [7];
    nt = '{2, 6, 0, 0, 0, 1, 1};
    nn = '{0, 0, 1, 1, 2, 0, 0};
    ex = '{1, 1, 1, 0, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < nt[i]; k++) upd(FAR_PC, 6'h20, 1'b1, 32'h0000_0ABC);
      for (int k = 0; k < nn[i]; k++) upd(FAR_PC, 6'h20, 1'b0, 32'h0000_0ABC);
      drive_q(pc_for(6'h20, ghr_m), $sformatf("cnt2 step %0d", i),
              {ex[i], 1'b0, 32'd0, 6'h20});
      #2;
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e.v) begin
        n_bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_history();
    exp_t e;
    do_reset();
    upd(FAR_PC, 6'h3F, 1'b1, 32'h0000_0ABC);
    upd(FAR_PC, 6'h3F, 1'b0, 32'h0000_0ABC);
    upd(FAR_PC, 6'h3F, 1'b1, 32'h0000_0ABC);
    drive_q(32'h40, "history 101", {1'b0, 1'b0, 32'd0, 6'h25});
    #2;
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.v) begin
      n_bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v);
    end
    @(negedge clk);
  endtask

  task automatic test_btb();
    exp_t e;
    do_reset();
    upd(32'h80, 6'h00, 1'b1, 32'h200);
    drive_q(32'h80,  "btb hit",       {1'b0, 1'b1, 32'h200, 6'h01});
    drive_q(32'h880, "btb tag miss",  {1'b0, 1'b0, 32'd0,   6'h01});
    for (int i = 0; i < 2; i++) begin
      query_pc = (i == 0) ? 32'h80 : 32'h880;
      #2;
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e.v) begin
        n_bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v);
      end
      @(negedge clk);
    end
    upd(32'h80, 6'h00, 1'b0, 32'h999);
    drive_q(32'h80, "btb kept after not-taken", {1'b0, 1'b1, 32'h200, 6'h02});
    #2;
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.v) begin
      n_bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v);
    end
    @(negedge clk);
  endtask

  task automatic test_rdy_rst();
    exp_t e;
    do_reset();
    rdy = 1'b0;
    upd(32'h80, 6'h20, 1'b1, 32'h300);
    rdy = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 2; i++) begin
        if (i == 0) drive_q(32'h40, $sformatf("%s pht/ghr", r == 0 ? "rdy0" : "rst+upd"),
                            {1'b0, 1'b0, 32'd0, 6'h20});
        else        drive_q(32'h80, $sformatf("%s btb", r == 0 ? "rdy0" : "rst+upd"),
                            {1'b0, 1'b0, 32'd0, 6'h00});
        #2;
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e.v) begin
          n_bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v);
        end
        @(negedge clk);
      end
      if (r == 0) begin
        rst = 1'b1;
        upd(32'h80, 6'h20, 1'b1, 32'h300);
        rst = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    update = 1'b1; update_pc = 32'h40; update_index = 6'h20; update_result = 1'b1;
    update_target = 32'h1234;
    drive_q(32'h40, "same-cycle old value", {1'b0, 1'b0, 32'd0, 6'h20});
    #2;
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.v) begin
      n_bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v);
    end
    @(negedge clk);
    update = 1'b0; ghr_m = {ghr_m[4:0], 1'b1};
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive_q(pc_for(6'h20, ghr_m), "next-cycle new pht",
                          {1'b1, 1'b0, 32'd0, 6'h20});
      else        drive_q(32'h40, "next-cycle new btb", {1'b0, 1'b1, 32'h1234, 6'h21});
      #2;
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e.v) begin
        n_bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_cnt3();
    exp_t e;
    int   nt [5];
    int   nn [5];
    logic ex [5];
    nt = '{0, 1, 10, 0, 0};
    nn = '{0, 0, 0,  3, 1};
    ex = '{0, 1, 1,  1, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < nt[i]; k++) upd3(6'h20, 1'b1);
      for (int k = 0; k < nn[i]; k++) upd3(6'h20, 1'b0);
      drive_q3(pc_for(6'h20, g3), $sformatf("cnt3 step %0d", i),
               {ex[i], 1'b0, 32'd0, 6'h20});
      #2;
      e = exp_q.pop_front(); n_cmp++;
      if (obs3 !== e.v) begin
        n_bad++; $display("FAIL %s: got %h want %h", e.nm, obs3, e.v);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; query_pc = '0; query_pc3 = '0;
    update = 1'b0; update_pc = '0; update_index = '0; update_result = 1'b0; update_target = '0;
    update3 = 1'b0; update_pc3 = '0; update_index3 = '0; update_result3 = 1'b0;
    update_target3 = '0; ghr_m = '0; g3 = '0;
    @(negedge clk);
    test_reset();
    test_counter();
    test_history();
    test_btb();
    test_rdy_rst();
    test_back_to_back();
    test_cnt3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
